// File: rtl/psum_acc_tree.sv
// rtl/psum_acc_tree.sv - pipelined multi-lane partial-sum adder tree with frame accumulator
//
// Sums NUM_IN signed lanes per accepted beat through one input register stage and
// L = clog2(NUM_IN) registered adder levels, accumulates beats until the last beat
// of a frame, then adds the frame bias, shifts right arithmetically and saturates.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active low
//   s_valid  input beat valid
//   s_ready  block can accept a beat (low while a result is stalled)
//   s_data   NUM_IN lanes, lane i at [i*DWIDTH +: DWIDTH]
//   s_last   beat closes the frame
//   s_bias   frame bias, used only with s_last
//   m_valid  result valid
//   m_ready  downstream accepts result
//   m_data   saturated frame result
//   m_sat    saturation occurred somewhere in this frame
module psum_acc_tree #(
    parameter int DWIDTH    = 16,
    parameter int NUM_IN    = 4,
    parameter int MAX_BEATS = 256,
    parameter int SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [NUM_IN*DWIDTH-1:0] s_data,
    input  logic                     s_last,
    input  logic [DWIDTH-1:0]        s_bias,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DWIDTH-1:0]        m_data,
    output logic                     m_sat
);

    localparam int L     = $clog2(NUM_IN);
    localparam int ACCW  = DWIDTH + L + $clog2(MAX_BEATS);
    localparam int RW    = ACCW + 2;
    localparam int NODES = 2 * NUM_IN - 1;

    // Stage k of the tree holds NUM_IN>>k nodes; all stages share one flat array.
    function automatic int off(input int k);
        return 2 * NUM_IN - 2 * (NUM_IN >> k);
    endfunction

    logic                      en;
    logic signed [ACCW-1:0]    node_q [NODES];
    logic [L:0]                vld_q;
    logic [L:0]                last_q;
    logic [L:0][DWIDTH-1:0]    bias_q;
    logic signed [ACCW-1:0]    acc_q;
    logic                      sticky_q;
    logic                      m_valid_q;
    logic [DWIDTH-1:0]         m_data_q;
    logic                      m_sat_q;

    logic signed [ACCW-1:0]    tree;
    logic [DWIDTH-1:0]         tbias;
    logic [ACCW:0]             acc_sum;
    logic                      acc_ovf;
    logic [ACCW-1:0]           acc_d;
    logic signed [RW-1:0]      fin_sum;
    logic signed [RW-1:0]      fin_sh;
    logic                      fin_ovf;
    logic [DWIDTH-1:0]         fin_d;

    // The whole pipeline freezes while a finished result waits for downstream.
    assign en      = !(m_valid_q && !m_ready);
    assign s_ready = en;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sat   = m_sat_q;

    assign tree  = node_q[NODES-1];
    assign tbias = bias_q[L];

    always_comb begin
        acc_sum = {acc_q[ACCW-1], acc_q} + {tree[ACCW-1], tree};
        acc_ovf = acc_sum[ACCW] != acc_sum[ACCW-1];
        acc_d   = acc_sum[ACCW-1:0];
        if (acc_ovf) begin
            acc_d = acc_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end

        fin_sum = {{2{acc_q[ACCW-1]}}, acc_q} + {{2{tree[ACCW-1]}}, tree}
                + {{(RW-DWIDTH){tbias[DWIDTH-1]}}, tbias};
        fin_sh  = fin_sum >>> SHIFT;
        // Fits in DWIDTH only if every bit above the result sign matches it.
        fin_ovf = fin_sh[RW-1:DWIDTH-1] != {(RW-DWIDTH+1){fin_sh[RW-1]}};
        fin_d   = fin_sh[DWIDTH-1:0];
        if (fin_ovf) begin
            fin_d = fin_sh[RW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NODES; j++) begin
                node_q[j] <= '0;
            end
            vld_q     <= '0;
            last_q    <= '0;
            bias_q    <= '0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sat_q   <= 1'b0;
        end else if (en) begin
            for (int j = 0; j < NUM_IN; j++) begin
                node_q[j] <= {{(ACCW-DWIDTH){s_data[j*DWIDTH+DWIDTH-1]}}, s_data[j*DWIDTH +: DWIDTH]};
            end
            vld_q[0]  <= s_valid;
            last_q[0] <= s_last;
            bias_q[0] <= s_bias;
            for (int k = 1; k <= L; k++) begin
                for (int j = 0; j < (NUM_IN >> k); j++) begin
                    node_q[off(k)+j] <= node_q[off(k-1)+2*j] + node_q[off(k-1)+2*j+1];
                end
                vld_q[k]  <= vld_q[k-1];
                last_q[k] <= last_q[k-1];
                bias_q[k] <= bias_q[k-1];
            end

            // With en=1 a held result has been taken, so m_valid only reflects a new load.
            m_valid_q <= vld_q[L] && last_q[L];
            if (vld_q[L]) begin
                if (last_q[L]) begin
                    m_data_q <= fin_d;
                    m_sat_q  <= sticky_q || fin_ovf;
                    acc_q    <= '0;
                    sticky_q <= 1'b0;
                end else begin
                    acc_q    <= acc_d;
                    sticky_q <= sticky_q || acc_ovf;
                end
            end
        end
    end

endmodule
